// File: rtl/line_arbiter.sv
// rtl/line_arbiter.sv - round-robin sequencer sharing one line engine among NUM_REQ requesters
// Optional BUSY watchdog enabled by defining LINE_ARB_TIMEOUT_EN.
module line_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [9*NUM_REQ-1:0]   req_x0,
    input  logic [9*NUM_REQ-1:0]   req_x1,
    input  logic [8*NUM_REQ-1:0]   req_y0,
    input  logic [8*NUM_REQ-1:0]   req_y1,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic                   timeout,
    output logic                   eng_go,
    output logic [8:0]             eng_x0,
    output logic [8:0]             eng_x1,
    output logic [7:0]             eng_y0,
    output logic [7:0]             eng_y1,
    input  logic                   eng_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               done_q;
    logic               done_rise;
    int                 idx;

`ifdef LINE_ARB_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0]        wd_cnt;
`endif

    // Rotating priority: scan last+1, last+2, ... so the previous winner goes last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    // done stays high two cycles; only its leading edge finishes a line.
    assign done_rise = eng_done & ~done_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            last   <= IDX_W'(NUM_REQ - 1);
            grant  <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            eng_go <= 1'b0;
            eng_x0 <= '0;
            eng_x1 <= '0;
            eng_y0 <= '0;
            eng_y1 <= '0;
            done_q <= 1'b0;
`ifdef LINE_ARB_TIMEOUT_EN
            timeout <= 1'b0;
            wd_cnt  <= '0;
`endif
        end else begin
            done_q <= eng_done;
            ack    <= '0;
            eng_go <= 1'b0;
`ifdef LINE_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= NUM_REQ'(1) << pick;
                        eng_x0 <= req_x0[9*pick +: 9];
                        eng_x1 <= req_x1[9*pick +: 9];
                        eng_y0 <= req_y0[8*pick +: 8];
                        eng_y1 <= req_y1[8*pick +: 8];
                        last   <= pick;
                        eng_go <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef LINE_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    if (done_rise) begin
                        ack   <= grant;
                        state <= RELEASE;
                    end
`ifdef LINE_ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        ack     <= grant;
                        timeout <= 1'b1;
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
`endif
                end
                RELEASE: begin
                    // Holding here until done drops keeps go out of the engine's second done cycle.
                    if (!eng_done) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef LINE_ARB_TIMEOUT_EN
    assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
